// File: rtl/pulse_counter_19_if.sv
// pulse_counter_19_if -- groups the button/clear inputs and count outputs of
// pulse_counter_19.
//   btn_up, btn_down : raw asynchronous push-buttons (driven by master)
//   clear            : synchronous count clear (driven by master)
//   amount           : registered count 0..19 (driven by slave)
//   at_max, at_min   : amount == 19 / amount == 0 flags (driven by slave)
//   changed          : one-cycle pulse when amount takes a new value
interface pulse_counter_19_if;
  logic       btn_up;
  logic       btn_down;
  logic       clear;
  logic [4:0] amount;
  logic       at_max;
  logic       at_min;
  logic       changed;

  modport master (
    output btn_up, btn_down, clear,
    input  amount, at_max, at_min, changed
  );

  modport slave (
    input  btn_up, btn_down, clear,
    output amount, at_max, at_min, changed
  );
endinterface

// File: rtl/pulse_counter_19.sv
// pulse_counter_19 -- up/down decimal counter (0..19) driven by two debounced
// push-buttons.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pulse_counter_19_if.slave (btn_up, btn_down, clear in;
//           amount, at_max, at_min, changed out)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synced cycles before a level is
//                     accepted (1..15)
//   WRAP            : 1 = count wraps 19<->0, 0 = saturates at 19 and 0
module pulse_counter_19 #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit WRAP            = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  pulse_counter_19_if.slave bus
);

  localparam logic [4:0] MAX_AMT  = 5'd19;
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  // Index 0 = up button, index 1 = down button.
  logic [1:0]      sync_p0;
  logic [1:0]      sync_p1;
  logic [1:0][3:0] db_cnt;
  logic [1:0]      db_p2;
  logic [1:0]      db_p3;
  logic [1:0]      evt;
  logic [4:0]      amount_q;
  logic [4:0]      amount_nxt;
  logic            changed_q;

  function automatic logic [4:0] step_up(input logic [4:0] a);
    if (a >= MAX_AMT) step_up = WRAP ? 5'd0 : MAX_AMT;
    else              step_up = a + 5'd1;
  endfunction

  function automatic logic [4:0] step_down(input logic [4:0] a);
    if (a == 5'd0)        step_down = WRAP ? MAX_AMT : 5'd0;
    else if (a > MAX_AMT) step_down = MAX_AMT;
    else                  step_down = a - 5'd1;
  endfunction

  // Rising edge of the debounced level only; release produces nothing.
  assign evt = db_p2 & ~db_p3;

  always_comb begin
    amount_nxt = amount_q;
    if (bus.clear)           amount_nxt = 5'd0;
    else if (evt == 2'b11)   amount_nxt = amount_q;
    else if (evt[0])         amount_nxt = step_up(amount_q);
    else if (evt[1])         amount_nxt = step_down(amount_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      db_cnt    <= '0;
      db_p2     <= '0;
      db_p3     <= '0;
      amount_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchronizer per button.
      sync_p0 <= {bus.btn_down, bus.btn_up};
      sync_p1 <= sync_p0;
      // Stage p2: debouncer; level flips on the edge the counter would hit
      // DEBOUNCE_CYCLES, and the counter restarts whenever levels agree.
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == db_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_p2[i]  <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 4'd1;
        end
      end
      // Stage p3: edge history for press detection.
      db_p3 <= db_p2;
      // Count register; changed flags a real value change only.
      amount_q  <= amount_nxt;
      changed_q <= (amount_nxt != amount_q);
    end
  end

  assign bus.amount  = amount_q;
  assign bus.changed = changed_q;
  assign bus.at_max  = (amount_q == MAX_AMT);
  assign bus.at_min  = (amount_q == 5'd0);

endmodule
